// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding, packet layout and default guard gaps for the SPI command sequencer
package spi_seq_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int PKT_W = 24;
  localparam int CMD_HI = 23, CMD_LO = 20;
  localparam int ADDR_HI = 19, ADDR_LO = 16;
  localparam int VALUE_HI = 15, VALUE_LO = 0;
  localparam int CFG_W = 12;
  localparam int DEF_DAC_GAP = 28;
  localparam int DEF_SR_GAP = 20;
endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: synchronous FIFO with wrap-around pointers, occupancy level and dropped-write flag
module spi_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 24
) (
  input  logic                     clk25,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic push;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  // a pop frees the slot in the same cycle, so a write to a full FIFO is kept then
  assign push = wr_en && (!full || rd_en);
  assign drop = wr_en && !push;
  assign rd_data = mem_q[rptr_q];
  always_ff @(posedge clk25)
    if (push) mem_q[wptr_q] <= wr_data;
  always_ff @(posedge clk25)
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: paces DAC sends and shift-register updates to the serializer; SPI_CMD_SEQ_DROP_CNT_EN adds drop_cnt
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DAC_GAP = DEF_DAC_GAP,
  parameter int SR_GAP = DEF_SR_GAP
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [23:0]                   wr_data,
  input  logic [1:0]                    led_en,
  input  logic [1:0]                    led_val,
  input  logic [3:0]                    cal_mux,
  input  logic [3:0]                    pga_cs,
  input  logic                          sr_kick,
  input  logic                          ovf_clr,
  output logic [23:0]                   dac_packet,
  output logic                          dac_send,
  output logic                          shiftreg_update,
  output logic [1:0]                    led_en_o,
  output logic [1:0]                    led_val_o,
  output logic [3:0]                    cal_mux_o,
  output logic [3:0]                    pga_cs_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          busy,
  output logic                          overflow
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
  ,output logic [7:0]                   drop_cnt
`endif
);
  localparam int GMAX = DAC_GAP > SR_GAP ? DAC_GAP : SR_GAP;
  localparam int CW = $clog2(GMAX);
  state_t state_q;
  logic [CW-1:0] gap_q;
  logic [CFG_W-1:0] cfg, snap_q;
  logic [PKT_W-1:0] head;
  logic sr_pend_q, sr_pend_d, last_dac_q, overflow_q, empty, drop, issue_dac, issue_sr;
  assign cfg = {led_en, led_val, cal_mux, pga_cs};
  assign {led_en_o, led_val_o, cal_mux_o, pga_cs_o} = snap_q;
  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo (
    .clk25(clk25), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(issue_dac),
    .rd_data(head), .level(fifo_level), .full(fifo_full), .empty(empty), .drop(drop)
  );
  // when both are pending, last_dac hands the next slot to the shift register
  assign issue_sr = state_q == IDLE && sr_pend_q && (empty || last_dac_q);
  assign issue_dac = state_q == IDLE && !empty && !(sr_pend_q && last_dac_q);
  assign sr_pend_d = !issue_sr && (sr_pend_q || sr_kick || cfg != snap_q);
  assign busy = !empty || sr_pend_q || state_q != IDLE;
  assign overflow = overflow_q;
  always_ff @(posedge clk25)
    if (reset) begin
      state_q <= IDLE;
      gap_q <= '0;
      sr_pend_q <= 1'b1;
      last_dac_q <= 1'b0;
      snap_q <= '0;
      dac_packet <= '0;
      dac_send <= 1'b0;
      shiftreg_update <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dac_send <= issue_dac;
      shiftreg_update <= issue_sr;
      sr_pend_q <= sr_pend_d;
      overflow_q <= drop || (overflow_q && !ovf_clr);
      if (issue_dac) begin
        dac_packet <= {head[CMD_HI:CMD_LO], head[ADDR_HI:ADDR_LO], head[VALUE_HI:VALUE_LO]};
        gap_q <= CW'(DAC_GAP - 1);
        last_dac_q <= 1'b1;
        state_q <= WAIT;
      end else if (issue_sr) begin
        snap_q <= cfg;
        gap_q <= CW'(SR_GAP - 1);
        last_dac_q <= 1'b0;
        state_q <= WAIT;
      end else if (state_q == WAIT) begin
        gap_q <= gap_q - 1'b1;
        state_q <= gap_q == CW'(1) ? IDLE : WAIT;
      end
    end
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
  always_ff @(posedge clk25)
    if (reset) drop_cnt <= '0;
    else if (drop) drop_cnt <= drop_cnt == 8'hff ? drop_cnt : drop_cnt + 1'b1;
    else if (ovf_clr) drop_cnt <= '0;
`endif
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed and randomized checks against a queue/timestamp model of the sequencer
module tb_spi_cmd_sequencer;
  localparam int FD = 8, DG = 28, SG = 20, LW = $clog2(FD) + 1;
  logic clk25 = 0, reset = 1, wr_en = 0, sr_kick = 0, ovf_clr = 0;
  logic [23:0] wr_data = 0;
  logic [1:0] led_en = 0, led_val = 0;
  logic [3:0] cal_mux = 0, pga_cs = 0;
  logic [23:0] dac_packet;
  logic dac_send, shiftreg_update, fifo_full, busy, overflow;
  logic [1:0] led_en_o, led_val_o;
  logic [3:0] cal_mux_o, pga_cs_o;
  logic [LW-1:0] fifo_level;
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int total = 0, bad = 0;
  always #20 clk25 = ~clk25;
  spi_cmd_sequencer #(.FIFO_DEPTH(FD), .DAC_GAP(DG), .SR_GAP(SG)) dut (
    .clk25(clk25), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .led_en(led_en), .led_val(led_val), .cal_mux(cal_mux), .pga_cs(pga_cs),
    .sr_kick(sr_kick), .ovf_clr(ovf_clr), .dac_packet(dac_packet), .dac_send(dac_send),
    .shiftreg_update(shiftreg_update), .led_en_o(led_en_o), .led_val_o(led_val_o),
    .cal_mux_o(cal_mux_o), .pga_cs_o(pga_cs_o), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .busy(busy), .overflow(overflow)
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, a, e, n);
    end
  endtask
  // model: a packet queue, a pending-refresh bit and the edge index at which the next pulse may issue
  logic [23:0] q[$];
  int n = 0, ready_at = 0, e_drop = 0;
  bit mv = 0, pend = 0, last_dac = 0, e_ovf = 0, e_send = 0, e_upd = 0;
  logic [11:0] snap = 0;
  logic [23:0] e_pkt = 0;
  initial forever begin
    @(posedge clk25);
    n++;
    if (reset) begin
      q.delete();
      ready_at = n + 1;
      pend = 1; last_dac = 0; snap = 0; e_pkt = 0; e_send = 0; e_upd = 0; e_ovf = 0; e_drop = 0; mv = 1;
    end else begin
      bit can, sr, dac, drop;
      logic [11:0] cfg;
      cfg = {led_en, led_val, cal_mux, pga_cs};
      can = n >= ready_at;
      sr = can && pend && (q.size() == 0 || last_dac);
      dac = can && q.size() > 0 && !sr;
      e_send = dac;
      e_upd = sr;
      if (dac) begin e_pkt = q.pop_front(); ready_at = n + DG; last_dac = 1; end
      pend = !sr && (pend || sr_kick || cfg != snap);
      if (sr) begin snap = cfg; ready_at = n + SG; last_dac = 0; end
      drop = wr_en && q.size() == FD;
      if (wr_en && !drop) q.push_back(wr_data);
      if (drop) begin e_ovf = 1; if (e_drop < 255) e_drop++; end
      else if (ovf_clr) begin e_ovf = 0; e_drop = 0; end
    end
  end
  int sends[$], upds[$];
  logic [23:0] pkts[$];
  initial forever begin
    @(negedge clk25);
    if (dac_send) begin sends.push_back(n); pkts.push_back(dac_packet); end
    if (shiftreg_update) upds.push_back(n);
    if (mv) begin
      chk("dac_packet", 32'(dac_packet), 32'(e_pkt));
      chk("dac_send", 32'(dac_send), 32'(e_send));
      chk("shiftreg_update", 32'(shiftreg_update), 32'(e_upd));
      chk("snapshot", 32'({led_en_o, led_val_o, cal_mux_o, pga_cs_o}), 32'(snap));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("fifo_full", 32'(fifo_full), 32'(q.size() == FD));
      chk("busy", 32'(busy), 32'(q.size() > 0 || pend || n + 1 < ready_at));
      chk("overflow", 32'(overflow), 32'(e_ovf));
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
`endif
    end
  end
  initial begin
    int hit;
    int burst;
    repeat (3) @(negedge clk25);
    reset = 0;
    @(negedge clk25); chk("sr_after_reset", 32'(shiftreg_update), 1);
    repeat (18) @(negedge clk25); chk("busy_in_gap", 32'(busy), 1);
    @(negedge clk25); chk("busy_idle", 32'(busy), 0);
    wr_en = 1; wr_data = 24'h3A1234;
    @(negedge clk25); wr_en = 0;
    chk("send_early", 32'(dac_send), 0);
    @(negedge clk25);
    chk("send_lat2", 32'(dac_send), 1);
    chk("pkt_3a1234", 32'(dac_packet), 32'h3A1234);
    repeat (10) @(negedge clk25); chk("pkt_held", 32'(dac_packet), 32'h3A1234);
    repeat (25) @(negedge clk25);
    sends.delete(); pkts.delete();
    for (int i = 0; i < 3; i++) begin wr_en = 1; wr_data = 24'h000100 + 24'(i); @(negedge clk25); end
    wr_en = 0;
    repeat (100) @(negedge clk25);
    chk("three_sends", 32'(sends.size()), 3);
    if (sends.size() == 3) begin
      chk("gap01", 32'(sends[1] - sends[0]), 28);
      chk("gap12", 32'(sends[2] - sends[1]), 28);
      for (int i = 0; i < 3; i++) chk("order", 32'(pkts[i]), 32'h100 + 32'(i));
    end
    sends.delete(); upds.delete();
    wr_en = 1; wr_data = 24'hAAAAAA; @(negedge clk25); wr_en = 0;
    repeat (5) @(negedge clk25);
    wr_en = 1; wr_data = 24'hBBBBBB; cal_mux = 4'b0101; @(negedge clk25); wr_en = 0;
    repeat (80) @(negedge clk25);
    chk("arb_sends", 32'(sends.size()), 2);
    chk("arb_upds", 32'(upds.size()), 1);
    if (sends.size() == 2 && upds.size() == 1) begin
      chk("dac_to_sr", 32'(upds[0] - sends[0]), 28);
      chk("sr_to_dac", 32'(sends[1] - upds[0]), 20);
    end
    chk("cal_mux_o", 32'(cal_mux_o), 32'h5);
    sends.delete(); pkts.delete();
    wr_en = 1; wr_data = 24'hC00000; @(negedge clk25);
    for (int i = 1; i <= 9; i++) begin wr_data = 24'hC00000 + 24'(i); @(negedge clk25); end
    wr_en = 0;
    chk("full", 32'(fifo_full), 1);
    chk("ovf_set", 32'(overflow), 1);
    chk("level8", 32'(fifo_level), 8);
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
    chk("drop1", 32'(drop_cnt), 1);
`endif
    repeat (300) @(negedge clk25);
    chk("sent9", 32'(sends.size()), 9);
    hit = 0;
    foreach (pkts[i]) if (pkts[i] == 24'hC00009) hit++;
    chk("ninth_dropped", 32'(hit), 0);
    ovf_clr = 1; @(negedge clk25); ovf_clr = 0;
    chk("ovf_clr", 32'(overflow), 0);
`ifdef SPI_CMD_SEQ_DROP_CNT_EN
    chk("drop_clr", 32'(drop_cnt), 0);
`endif
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = 24'hD00000 + 24'(i); @(negedge clk25); end
    wr_en = 0;
    repeat (3) @(negedge clk25);
    reset = 1; @(negedge clk25); reset = 0;
    chk("rst_pkt", 32'(dac_packet), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_send", 32'(dac_send), 0);
    chk("rst_cal", 32'(cal_mux_o), 0);
    sends.delete();
    repeat (100) @(negedge clk25);
    chk("no_send_after_rst", 32'(sends.size()), 0);
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = 12;
      wr_en = burst > 0 || $urandom_range(0, 99) < (c < 2000 ? 6 : 2);
      if (burst > 0) burst--;
      wr_data = 24'($urandom);
      if ($urandom_range(0, 99) == 0) {led_en, led_val, cal_mux, pga_cs} = 12'($urandom);
      sr_kick = $urandom_range(0, 199) == 0;
      ovf_clr = $urandom_range(0, 149) == 0;
      reset = $urandom_range(0, 999) == 0;
      @(negedge clk25);
    end
    wr_en = 0; sr_kick = 0; ovf_clr = 0; reset = 0;
    repeat (5) @(negedge clk25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
